macc_job_sched: RTL and testbench

Round-robin job scheduler that shares one pipelined multiply-accumulate unit among `NREQ` requesters. Each requester submits a dot-product job (a length, then a stream of operand pairs). The scheduler:
- grants one job at a time;
- drives the MAC's `ce`, `sload` and operand inputs;
- stalls the pipeline on operand gaps, drains it with zero beats;
- returns the captured accumulation tagged with the requester ID.

It sits between the requesting engines and the MAC instance in the DSP datapath.

---
 rtl/macc_job_sched.sv | 181 ++++++++++++++++++
 tb/tb_macc_job_sched.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_job_sched.sv
// Round-robin job scheduler sharing one pipelined MAC among NREQ requesters.
// Define MACC_SCHED_TIMEOUT_EN to abort jobs whose operand stream stalls for TMO cycles.
module macc_job_sched #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned SIZEIN  = 16,
  parameter int unsigned SIZEOUT = 40,
  parameter int unsigned LENW    = 8,
  parameter int unsigned TMO     = 64,
  localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*LENW-1:0]     req_len,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          op_valid,
  input  logic [NREQ*SIZEIN-1:0]   op_a,
  input  logic [NREQ*SIZEIN-1:0]   op_b,
  output logic [NREQ-1:0]          op_ready,
  output logic                     mac_ce,
  output logic                     mac_sload,
  output logic [SIZEIN-1:0]        mac_a,
  output logic [SIZEIN-1:0]        mac_b,
  input  logic [SIZEOUT-1:0]       mac_acc,
  output logic                     res_valid,
  output logic [IDW-1:0]           res_id,
  output logic [SIZEOUT-1:0]       res_data,
  output logic                     res_err
);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_CAPTURE, S_RESULT} state_t;

  state_t             state, state_nx;
  logic [IDW-1:0]     gnt, gnt_nx;
  logic [IDW-1:0]     rr_ptr, rr_ptr_nx;
  logic [LENW-1:0]    cnt, cnt_nx;
  logic [1:0]         seen, seen_nx;
  logic               drn, drn_nx;
  logic               res_valid_nx;
  logic [IDW-1:0]     res_id_nx;
  logic [SIZEOUT-1:0] res_data_nx;
  logic               found;
  logic [IDW-1:0]     pick;
  logic [31:0]        rr_idx;
  logic               abort;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = (32'(rr_ptr) + 32'(k)) % 32'(NREQ);
      if (!found && req_valid[IDW'(rr_idx)]) begin
        found = 1'b1;
        pick  = IDW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      seen      <= '0;
      drn       <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      rr_ptr    <= rr_ptr_nx;
      cnt       <= cnt_nx;
      seen      <= seen_nx;
      drn       <= drn_nx;
      res_valid <= res_valid_nx;
      res_id    <= res_id_nx;
      res_data  <= res_data_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    rr_ptr_nx    = rr_ptr;
    cnt_nx       = cnt;
    seen_nx      = seen;
    drn_nx       = drn;
    res_valid_nx = 1'b0;
    res_id_nx    = res_id;
    res_data_nx  = res_data;
    req_ready    = '0;
    op_ready     = '0;
    mac_ce       = 1'b0;
    mac_sload    = 1'b0;
    mac_a        = '0;
    mac_b        = '0;

    unique case (state)
      S_IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          gnt_nx    = pick;
          cnt_nx    = req_len[pick*LENW +: LENW];
          rr_ptr_nx = (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
          seen_nx   = '0;
          drn_nx    = 1'b0;
          if (req_len[pick*LENW +: LENW] == '0) begin
            state_nx    = S_RESULT;
            res_id_nx   = pick;
            res_data_nx = '0;
          end else begin
            state_nx = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        op_ready[gnt] = 1'b1;
        if (op_valid[gnt]) begin
          mac_ce = 1'b1;
          mac_a  = op_a[gnt*SIZEIN +: SIZEIN];
          mac_b  = op_b[gnt*SIZEIN +: SIZEIN];
          cnt_nx = cnt - 1'b1;
          if (cnt == LENW'(1)) state_nx = S_DRAIN;
        end else if (abort) begin
          state_nx    = S_RESULT;
          res_id_nx   = gnt;
          res_data_nx = '0;
        end
      end
      S_DRAIN: begin
        mac_ce = 1'b1;
        drn_nx = 1'b1;
        if (drn) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_data_nx = mac_acc;
        res_id_nx   = gnt;
        state_nx    = S_RESULT;
      end
      S_RESULT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase

    // sload on the second ce beat clears stale feedback as the first product reaches the adder.
    if (mac_ce) begin
      mac_sload = (seen == 2'd1);
      seen_nx   = (seen == 2'd2) ? seen : seen + 2'd1;
    end

    res_valid_nx = (state_nx == S_RESULT);
  end

`ifdef MACC_SCHED_TIMEOUT_EN
  localparam int unsigned STW = $clog2(TMO + 1);
  logic [STW-1:0] stall;

  // Consecutive gap cycles in STREAM; any beat or leaving STREAM restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall <= '0;
    else if (state != S_STREAM || op_valid[gnt]) stall <= '0;
    else                                      stall <= stall + 1'b1;
  end

  assign abort = (state == S_STREAM) && !op_valid[gnt] && (stall == STW'(TMO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    res_err <= 1'b0;
    else if (state_nx == S_RESULT) res_err <= abort;
  end
`else
  logic unused_tmo;
  assign abort      = 1'b0;
  assign res_err    = 1'b0;
  assign unused_tmo = ^32'(TMO);
`endif

endmodule

// File: tb/tb_macc_job_sched.sv
// Bench for macc_job_sched: behavioural MAC, scoreboarded results, vector table plus corner sequences.
module tb_macc_job_sched;
  localparam int unsigned NREQ = 2, SIZEIN = 16, SIZEOUT = 32, LENW = 9, TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid, req_ready, op_valid, op_ready;
  logic [NREQ*LENW-1:0]   req_len;
  logic [NREQ*SIZEIN-1:0] op_a, op_b;
  logic                   mac_ce, mac_sload;
  logic [SIZEIN-1:0]      mac_a, mac_b;
  logic [SIZEOUT-1:0]     mac_acc;
  logic                   res_valid, res_err;
  logic [0:0]             res_id;
  logic [SIZEOUT-1:0]     res_data;

  logic rv0 = 1'b0, rv1 = 1'b0, ov0 = 1'b0, ov1 = 1'b0;
  logic [LENW-1:0]   rl0 = '0, rl1 = '0;
  logic [SIZEIN-1:0] oa0 = '0, ob0 = '0, oa1 = '0, ob1 = '0;
  assign req_valid = {rv1, rv0};
  assign req_len   = {rl1, rl0};
  assign op_valid  = {ov1, ov0};
  assign op_a      = {oa1, oa0};
  assign op_b      = {ob1, ob0};

  always #5 clk = ~clk;

  macc_job_sched #(.NREQ(NREQ), .SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .LENW(LENW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .mac_ce(mac_ce), .mac_sload(mac_sload), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_err(res_err)
  );

  // Two-stage pipelined MAC with sload applied one stage late, as in the DSP macro.
  logic signed [SIZEIN-1:0]  m_a = '0, m_b = '0;
  logic        [SIZEOUT-1:0] m_mult = '0, m_add = '0;
  logic                      m_sl = 1'b0;
  always @(posedge clk) begin
    if (mac_ce) begin
      m_a    <= mac_a;
      m_b    <= mac_b;
      m_mult <= SIZEOUT'(int'(m_a) * int'(m_b));
      m_sl   <= mac_sload;
      m_add  <= (m_sl ? '0 : m_add) + m_mult;
    end
  end
  assign mac_acc = m_add;

  typedef struct {
    int                 id;
    logic [SIZEOUT-1:0] data;
    logic               err;
    int                 ce;
    int                 sl;
  } exp_t;

  typedef struct {
    int                id;
    int                len;
    logic [SIZEIN-1:0] a [4];
    logic [SIZEIN-1:0] b [4];
    logic [SIZEOUT-1:0] exp;
  } vec_t;

  exp_t sb[$];
  int   gnt_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   ce_cnt = 0, sl_cnt = 0, sl_idx = -1, last_res_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor: pops the scoreboard and checks MAC usage of the finished job.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        gnt_q.push_back(req_ready[1] ? 1 : 0);
        ce_cnt = 0;
        sl_cnt = 0;
        sl_idx = -1;
      end
      if (mac_ce) begin
        if (mac_sload) begin
          sl_cnt++;
          sl_idx = ce_cnt;
        end
        ce_cnt++;
      end
      if (res_valid) begin
        last_res_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id %0d data 0x%0h, expected no result", res_id, res_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_id", 64'(res_id), 64'(e.id));
          check("res_data", 64'(res_data), 64'(e.data));
          check("res_err", 64'(res_err), 64'(e.err));
          check("ce_beats", 64'(ce_cnt), 64'(e.ce));
          check("sload_count", 64'(sl_cnt), 64'(e.sl));
          if (e.sl != 0) check("sload_beat", 64'(sl_idx), 64'd1);
        end
      end
    end
  end

  task automatic set_req(input int id, input logic v, input int len);
    if (id == 0) begin rv0 = v; rl0 = LENW'(len); end
    else         begin rv1 = v; rl1 = LENW'(len); end
  endtask

  task automatic set_op(input int id, input logic v, input logic [SIZEIN-1:0] a, input logic [SIZEIN-1:0] b);
    if (id == 0) begin ov0 = v; oa0 = a; ob0 = b; end
    else         begin ov1 = v; oa1 = a; ob1 = b; end
  endtask

  function automatic logic [SIZEOUT-1:0] dot(input logic [SIZEIN-1:0] av [256],
                                             input logic [SIZEIN-1:0] bv [256], input int len);
    logic [SIZEOUT-1:0] s;
    s = '0;
    for (int k = 0; k < len; k++)
      s += SIZEOUT'(int'($signed(av[k])) * int'($signed(bv[k])));
    return s;
  endfunction

  task automatic rand_ops(output logic [SIZEIN-1:0] av [256], output logic [SIZEIN-1:0] bv [256]);
    for (int k = 0; k < 256; k++) begin
      av[k] = SIZEIN'($urandom);
      bv[k] = SIZEIN'($urandom);
    end
  endtask

  // Waits at negedges for the grant; returns with the grant seen, or flags a timeout.
  task automatic wait_grant(input int id, output logic ok);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (req_ready[id] || t >= 400) break;
      t++;
      @(posedge clk); #1;
    end
    ok = req_ready[id];
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: requester %0d got no req_ready, expected a grant", id);
    end
  endtask

  // Called #1 after a posedge; returns #1 after a posedge. c0 is the cycle of the first beat.
  task automatic run_job(input int id, input int len, input logic [SIZEIN-1:0] av [256],
                         input logic [SIZEIN-1:0] bv [256], input logic [SIZEOUT-1:0] exp,
                         input int gap_at, input int gap_len, output int c0);
    int   t;
    logic ok;
    c0 = -1;
    set_req(id, 1'b1, len);
    wait_grant(id, ok);
    if (!ok) begin
      set_req(id, 1'b0, 0);
      return;
    end
    sb.push_back(exp_t'{id, exp, 1'b0, (len == 0) ? 0 : len + 2, (len == 0) ? 0 : 1});
    @(posedge clk); #1;
    set_req(id, 1'b0, 0);
    for (int k = 0; k < len; k++) begin
      if (k == gap_at) begin
        set_op(id, 1'b0, '0, '0);
        repeat (gap_len) @(posedge clk);
        #1;
      end
      set_op(id, 1'b1, av[k], bv[k]);
      t = 0;
      forever begin
        @(negedge clk);
        if (op_ready[id] || t >= 400) break;
        t++;
        @(posedge clk); #1;
      end
      if (!op_ready[id]) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: requester %0d beat %0d not accepted, expected op_ready", id, k);
        set_op(id, 1'b0, '0, '0);
        return;
      end
      if (k == 0) c0 = cyc;
      @(posedge clk); #1;
    end
    set_op(id, 1'b0, '0, '0);
  endtask

  task automatic drain_sb();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input int id, input int len, input int a0, input int b0, input int a1,
                              input int b1, input int a2, input int b2, input int a3, input int b3,
                              input int ex);
    vec_t v;
    v.id = id;  v.len = len;
    v.a[0] = SIZEIN'(a0); v.b[0] = SIZEIN'(b0);
    v.a[1] = SIZEIN'(a1); v.b[1] = SIZEIN'(b1);
    v.a[2] = SIZEIN'(a2); v.b[2] = SIZEIN'(b2);
    v.a[3] = SIZEIN'(a3); v.b[3] = SIZEIN'(b3);
    v.exp = SIZEOUT'(ex);
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t              vt [5];
    logic [SIZEIN-1:0] av [256];
    logic [SIZEIN-1:0] bv [256];
    int                c0, first;
    logic              ok;

    vt[0] = mk(0, 3,      2,      3,     -4,     5, 7, 1, 0, 0,    -7);
    vt[1] = mk(1, 1,     -3,     -3,      0,     0, 0, 0, 0, 0,     9);
    vt[2] = mk(0, 0,      0,      0,      0,     0, 0, 0, 0, 0,     0);
    vt[3] = mk(1, 4,      1,      2,      3,     4, 5, 6, 7, 8,   100);
    vt[4] = mk(0, 2, -32768, -32768, -32768, 32767, 0, 0, 0, 0, 32768);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 64'({req_ready, op_ready, mac_ce, mac_sload, res_valid, res_err, res_id}), 64'd0);
    check("rst_mac_ab", 64'({mac_a, mac_b}), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 256; k++) begin
        av[k] = (k < 4) ? vt[i].a[k] : '0;
        bv[k] = (k < 4) ? vt[i].b[k] : '0;
      end
      run_job(vt[i].id, vt[i].len, av, bv, vt[i].exp, -1, 0, c0);
      drain_sb();
      if (i == 0) check("latency_len3", 64'(last_res_cyc), 64'(c0 + 6));
    end

    // Three-cycle operand gap between beats 1 and 2.
    rand_ops(av, bv);
    run_job(1, 4, av, bv, dot(av, bv, 4), 2, 3, c0);
    drain_sb();
    check("latency_stall", 64'(last_res_cyc), 64'(c0 + 4 + 3 + 3));

    // Both requesters hold requests for four jobs each.
    first = (gnt_q.size() > 0) ? (gnt_q[$] + 1) % 2 : 0;
    gnt_q.delete();
    fork
      begin : req0_jobs
        logic [SIZEIN-1:0] xa [256];
        logic [SIZEIN-1:0] xb [256];
        int ln, cx;
        for (int j = 0; j < 4; j++) begin
          ln = 1 + int'($urandom_range(4, 0));
          rand_ops(xa, xb);
          run_job(0, ln, xa, xb, dot(xa, xb, ln), -1, 0, cx);
        end
      end
      begin : req1_jobs
        logic [SIZEIN-1:0] ya [256];
        logic [SIZEIN-1:0] yb [256];
        int ln, cy;
        for (int j = 0; j < 4; j++) begin
          ln = 1 + int'($urandom_range(4, 0));
          rand_ops(ya, yb);
          run_job(1, ln, ya, yb, dot(ya, yb, ln), -1, 0, cy);
        end
      end
    join
    drain_sb();
    check("contention_grants", 64'(gnt_q.size()), 64'd8);
    for (int k = 0; k < gnt_q.size() && k < 8; k++)
      check("contention_order", 64'(gnt_q[k]), 64'((first + k) % 2));

    gnt_q.delete();
    for (int j = 0; j < 3; j++) begin
      rand_ops(av, bv);
      run_job(1, 2 + j, av, bv, dot(av, bv, 2 + j), -1, 0, c0);
    end
    drain_sb();
    check("solo_grants", 64'(gnt_q.size()), 64'd3);
    for (int k = 0; k < gnt_q.size() && k < 3; k++)
      check("solo_order", 64'(gnt_q[k]), 64'd1);

    // 256 x 0x7FFF^2 wraps modulo 2^32.
    for (int k = 0; k < 256; k++) begin
      av[k] = 16'h7FFF;
      bv[k] = 16'h7FFF;
    end
    run_job(0, 256, av, bv, 32'hFF00_0100, -1, 0, c0);
    drain_sb();

    // Reset in the middle of a stream drops the job.
    set_req(0, 1'b1, 10);
    wait_grant(0, ok);
    @(posedge clk); #1;
    set_req(0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      set_op(0, 1'b1, 16'd5, 16'd5);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", 64'({req_ready, op_ready, mac_ce, mac_sload, res_valid, res_err}), 64'd0);
    check("rst_mid_ab", 64'({mac_a, mac_b}), 64'd0);
    check("rst_mid_res", 64'({res_id, res_data}), 64'd0);
    set_op(0, 1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // After reset rr_ptr is 0, so requester 0 wins a simultaneous request.
    gnt_q.delete();
    fork
      begin : post_rst0
        logic [SIZEIN-1:0] pa [256];
        logic [SIZEIN-1:0] pb [256];
        int cp;
        rand_ops(pa, pb);
        run_job(0, 3, pa, pb, dot(pa, pb, 3), -1, 0, cp);
      end
      begin : post_rst1
        logic [SIZEIN-1:0] qa [256];
        logic [SIZEIN-1:0] qb [256];
        int cq;
        rand_ops(qa, qb);
        run_job(1, 2, qa, qb, dot(qa, qb, 2), -1, 0, cq);
      end
    join
    drain_sb();
    check("post_rst_grants", 64'(gnt_q.size()), 64'd2);
    if (gnt_q.size() > 0) check("post_rst_first", 64'(gnt_q[0]), 64'd0);

`ifdef MACC_SCHED_TIMEOUT_EN
    begin : timeout_seq
      int b;
      b = -1;
      set_req(0, 1'b1, 3);
      wait_grant(0, ok);
      if (ok) sb.push_back(exp_t'{0, '0, 1'b1, 1, 0});
      @(posedge clk); #1;
      set_req(0, 1'b0, 0);
      set_op(0, 1'b1, 16'd9, 16'd9);
      @(negedge clk);
      if (op_ready[0]) b = cyc;
      @(posedge clk); #1;
      set_op(0, 1'b0, '0, '0);
      drain_sb();
      check("timeout_latency", 64'(last_res_cyc), 64'(b + 9));
      rand_ops(av, bv);
      run_job(1, 4, av, bv, dot(av, bv, 4), -1, 0, c0);
      drain_sb();
    end
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
